// File: rtl/pc_gen_mw_pkg.sv
`default_nettype none
// ============================================================================
// Package  : if_pkg
// Purpose  : Shared fetch-stage types and constants for the IF front end.
// Revision : 1.0
// ============================================================================
package if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam int          INSTR_BYTES      = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        IDLE = 2'd2
    } fetch_state_t;

    // Slot index width; a single-slot front end still carries a 1-bit index.
    function automatic int slot_width(input int fw);
        return (fw > 1) ? $clog2(fw) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_gen_mw_slot_mask_gen.sv
`default_nettype none
// ============================================================================
// Module   : slot_mask_gen
// Purpose  : Per-slot valid mask from group start offset and predicted-taken slot.
// Revision : 1.0
// ============================================================================
module slot_mask_gen #(
    parameter int FETCH_WIDTH = 2,
    parameter int SLOT_W      = 1
) (
    input  logic                   valid,
    input  logic [SLOT_W-1:0]      start,
    input  logic                   pred_taken,
    input  logic [SLOT_W-1:0]      pred_slot,
    output logic [FETCH_WIDTH-1:0] mask
);

    generate
        if (FETCH_WIDTH == 1) begin : g_single
            logic unused_idx;
            assign unused_idx = ^{start, pred_taken, pred_slot};
            assign mask       = valid;
        end else begin : g_multi
            for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
                localparam logic [SLOT_W-1:0] IDX = SLOT_W'(i);
                assign mask[i] = valid & (IDX >= start)
                                       & (~pred_taken | (IDX <= pred_slot));
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pc_gen_mw.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_mw
// Purpose  : Multi-wide fetch-group PC generator with redirect priority and
//            BOOT/RUN/IDLE sequencing. Optional PC_GEN_PERF_EN adds perf counters.
// Revision : 1.0
// ============================================================================
module pc_gen_mw
    import if_pkg::*;
#(
    parameter int          FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          SLOT_W      = slot_width(FETCH_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   excp_flush,
    input  logic [31:0]            excp_target,
    input  logic                   ex_br,
    input  logic [31:0]            ex_br_target,
    input  logic                   pred_taken,
    input  logic [SLOT_W-1:0]      pred_slot,
    input  logic [31:0]            pred_target,
    input  logic                   idle_req,
    input  logic [31:0]            idle_resume_pc,
    input  logic                   wake_int,
    input  logic                   stall_icache,
    input  logic                   stall_ibuf,
    output logic [31:0]            pc_if1,
    output logic [FETCH_WIDTH-1:0] slot_valid,
    output logic                   is_valid,
`ifdef PC_GEN_PERF_EN
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_redir_cnt,
    output logic [31:0]            perf_idle_cnt,
`endif
    output logic                   redirect_q
);

    localparam logic [1:0] ST_BOOT = BOOT;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_IDLE = IDLE;

    // Group alignment: FETCH_WIDTH instructions per group, 4-byte floor for width 1.
    localparam int          ALIGN_LSB  = (FETCH_WIDTH > 1) ? SLOT_W + 2 : 2;
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ALIGN_LSB) - 32'd1);
    localparam logic [31:0] GROUP_BYTES = 32'(INSTR_BYTES * FETCH_WIDTH);

    generate
        if (FETCH_WIDTH != 1 && FETCH_WIDTH != 2 && FETCH_WIDTH != 4) begin : g_bad_width
            $error("pc_gen_mw: FETCH_WIDTH must be 1, 2 or 4");
        end
    endgenerate

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [31:0]       pc_nxt;
    logic [31:0]       seq_pc;
    logic              stall;
    logic [SLOT_W-1:0] start;

    assign stall    = stall_icache | stall_ibuf;
    assign is_valid = (state == ST_RUN) & ~stall;
    assign seq_pc   = (pc_if1 & ALIGN_MASK) + GROUP_BYTES;
    assign start    = pc_if1[SLOT_W+1:2];

    slot_mask_gen #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .SLOT_W      (SLOT_W)
    ) u_slot_mask (
        .valid      (is_valid),
        .start      (start),
        .pred_taken (pred_taken),
        .pred_slot  (pred_slot),
        .mask       (slot_valid)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN:  if (idle_req && !excp_flush) state_nxt = ST_IDLE;
            ST_IDLE: if (wake_int || excp_flush)  state_nxt = ST_RUN;
            default: state_nxt = ST_BOOT;
        endcase
    end

    // Redirect priority: flush > EX branch > idle entry > hold > predictor > sequential.
    always_comb begin
        pc_nxt = pc_if1;
        if (excp_flush)
            pc_nxt = excp_target;
        else if (ex_br && state != ST_BOOT)
            pc_nxt = ex_br_target;
        else if (idle_req && state == ST_RUN)
            pc_nxt = idle_resume_pc;
        else if (state == ST_IDLE && wake_int)
            pc_nxt = pc_if1;
        else if (state != ST_RUN || stall)
            pc_nxt = pc_if1;
        else if (pred_taken)
            pc_nxt = pred_target;
        else
            pc_nxt = seq_pc;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_if1     <= RESET_PC;
            state      <= ST_BOOT;
            redirect_q <= 1'b0;
        end else begin
            pc_if1     <= pc_nxt;
            state      <= state_nxt;
            redirect_q <= excp_flush | ex_br;
        end
    end

`ifdef PC_GEN_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_stall_cnt <= 32'd0;
            perf_redir_cnt <= 32'd0;
            perf_idle_cnt  <= 32'd0;
        end else begin
            if (state == ST_RUN && stall && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if ((excp_flush || ex_br) && perf_redir_cnt != '1)
                perf_redir_cnt <= perf_redir_cnt + 32'd1;
            if (state == ST_IDLE && perf_idle_cnt != '1)
                perf_idle_cnt <= perf_idle_cnt + 32'd1;
        end
    end
`endif

    // Commit never retires an idle in the same cycle as an EX mispredict.
    a_no_br_with_idle: assert property (@(posedge clk) disable iff (!rstn)
                                        !(ex_br && idle_req));

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_mw.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen_mw
// Purpose  : Self-checking bench for pc_gen_mw at FETCH_WIDTH 2 and 4.
// Revision : 1.0
// ============================================================================
module tb_pc_gen_mw;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_IDLE = 2;
    localparam logic [31:0] RPC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        excp_flush, ex_br, pred_taken, idle_req, wake_int, stall_icache, stall_ibuf;
    logic [31:0] excp_target, ex_br_target, pred_target, idle_resume_pc;
    logic [1:0]  pred_slot;

    logic [31:0] pc2, pc4;
    logic [1:0]  sv2;
    logic [3:0]  sv4;
    logic        iv2, iv4, rq2, rq4;
`ifdef PC_GEN_PERF_EN
    logic [31:0] ps2, pr2, pi2, ps4, pr4, pi4;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc [2];
    int          m_st [2];
    bit          m_rq [2];

    always #5 clk = ~clk;

    pc_gen_mw #(.FETCH_WIDTH(2)) u2 (
        .clk(clk), .rstn(rstn),
        .excp_flush(excp_flush), .excp_target(excp_target),
        .ex_br(ex_br), .ex_br_target(ex_br_target),
        .pred_taken(pred_taken), .pred_slot(pred_slot[0]), .pred_target(pred_target),
        .idle_req(idle_req), .idle_resume_pc(idle_resume_pc), .wake_int(wake_int),
        .stall_icache(stall_icache), .stall_ibuf(stall_ibuf),
        .pc_if1(pc2), .slot_valid(sv2), .is_valid(iv2),
`ifdef PC_GEN_PERF_EN
        .perf_stall_cnt(ps2), .perf_redir_cnt(pr2), .perf_idle_cnt(pi2),
`endif
        .redirect_q(rq2)
    );

    pc_gen_mw #(.FETCH_WIDTH(4)) u4 (
        .clk(clk), .rstn(rstn),
        .excp_flush(excp_flush), .excp_target(excp_target),
        .ex_br(ex_br), .ex_br_target(ex_br_target),
        .pred_taken(pred_taken), .pred_slot(pred_slot), .pred_target(pred_target),
        .idle_req(idle_req), .idle_resume_pc(idle_resume_pc), .wake_int(wake_int),
        .stall_icache(stall_icache), .stall_ibuf(stall_ibuf),
        .pc_if1(pc4), .slot_valid(sv4), .is_valid(iv4),
`ifdef PC_GEN_PERF_EN
        .perf_stall_cnt(ps4), .perf_redir_cnt(pr4), .perf_idle_cnt(pi4),
`endif
        .redirect_q(rq4)
    );

    typedef struct {
        bit          excp;  logic [31:0] excp_t;
        bit          br;    logic [31:0] br_t;
        bit          pt;    logic [1:0]  ps;    logic [31:0] pt_t;
        bit          idle;  logic [31:0] idle_pc;
        bit          wake;  bit          stall;
        logic [31:0] e_pc;  bit          e_valid; logic [3:0] e_slot; bit e_rq;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(bit excp, logic [31:0] et, bit br, logic [31:0] bt,
                                bit pt, logic [1:0] ps, logic [31:0] ptt,
                                bit idle, logic [31:0] ipc, bit wake, bit stall,
                                logic [31:0] e_pc, bit e_valid, logic [3:0] e_slot, bit e_rq);
        vec_t v;
        v.excp = excp; v.excp_t = et; v.br = br; v.br_t = bt;
        v.pt = pt; v.ps = ps; v.pt_t = ptt; v.idle = idle; v.idle_pc = ipc;
        v.wake = wake; v.stall = stall;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_slot = e_slot; v.e_rq = e_rq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_inputs();
        excp_flush = 0; ex_br = 0; pred_taken = 0; idle_req = 0; wake_int = 0;
        stall_icache = 0; stall_ibuf = 0; pred_slot = 2'd0;
        excp_target = 0; ex_br_target = 0; pred_target = 0; idle_resume_pc = 0;
    endtask

    // Reference slot mask: a slot is fetched if it lies at/after the entry
    // offset and not beyond a predicted-taken branch.
    function automatic logic [3:0] exp_mask(int fw, logic [31:0] pc, bit valid, bit pt, int ps);
        logic [3:0] m = 4'b0;
        int st = int'((pc >> 2) % fw);
        if (!valid) return 4'b0;
        for (int i = 0; i < fw; i++)
            if (i >= st && (!pt || i <= ps)) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_check();
        bit stall = stall_icache | stall_ibuf;
        for (int k = 0; k < 2; k++) begin
            int  fw = (k == 1) ? 4 : 2;
            int  ps = int'(pred_slot) % fw;
            bit  ev = (m_st[k] == M_RUN) && !stall;
            logic [3:0] em = exp_mask(fw, m_pc[k], ev, pred_taken, ps);
            if (k == 1) begin
                chk("m4_pc", pc4, m_pc[1]);  chk("m4_valid", {31'b0, iv4}, {31'b0, ev});
                chk("m4_slot", {28'b0, sv4}, {28'b0, em}); chk("m4_rq", {31'b0, rq4}, {31'b0, m_rq[1]});
            end else begin
                chk("m2_pc", pc2, m_pc[0]);  chk("m2_valid", {31'b0, iv2}, {31'b0, ev});
                chk("m2_slot", {30'b0, sv2}, {30'b0, em[1:0]}); chk("m2_rq", {31'b0, rq2}, {31'b0, m_rq[0]});
            end
        end
    endtask

    task automatic tick();
        logic [31:0] n_pc [2];
        int          n_st [2];
        bit          n_rq [2];
        bit          stall = stall_icache | stall_ibuf;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] gb = (k == 1) ? 32'd16 : 32'd8;
            logic [31:0] pc = m_pc[k];
            int          st = m_st[k];
            if (excp_flush)                      n_pc[k] = excp_target;
            else if (ex_br && st != M_BOOT)      n_pc[k] = ex_br_target;
            else if (idle_req && st == M_RUN)    n_pc[k] = idle_resume_pc;
            else if (st != M_RUN || stall)       n_pc[k] = pc;
            else if (pred_taken)                 n_pc[k] = pred_target;
            else                                 n_pc[k] = pc - (pc % gb) + gb;
            if (st == M_BOOT)      n_st[k] = M_RUN;
            else if (st == M_RUN)  n_st[k] = (idle_req && !excp_flush) ? M_IDLE : M_RUN;
            else                   n_st[k] = (wake_int || excp_flush) ? M_RUN : M_IDLE;
            n_rq[k] = excp_flush | ex_br;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = n_pc[k]; m_st[k] = n_st[k]; m_rq[k] = n_rq[k];
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_pc4", pc4, RPC);          chk("rst_pc2", pc2, RPC);
        chk("rst_valid", {30'b0, iv4, iv2}, 32'd0);
        chk("rst_slot", {26'b0, sv4, sv2}, 32'd0);
        chk("rst_rq", {30'b0, rq4, rq2}, 32'd0);
`ifdef PC_GEN_PERF_EN
        chk("rst_perf", ps2 | pr2 | pi2 | ps4 | pr4 | pi4, 32'd0);
`endif
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = RPC; m_st[k] = M_BOOT; m_rq[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_inputs();
        //              excp et            br bt            pt ps   ptt           idle ipc           wk st   e_pc          v slot     rq
        tbl[0]  = mk(0, 0,            0, 0,            0, 2'd0, 0,            0, 0,            0, 0, 32'h1c000000, 0, 4'b0000, 0);
        tbl[1]  = mk(0, 0,            0, 0,            0, 2'd0, 0,            0, 0,            0, 0, 32'h1c000000, 1, 4'b1111, 0);
        tbl[2]  = mk(0, 0,            1, 32'h1c000024, 0, 2'd0, 0,            0, 0,            0, 0, 32'h1c000010, 1, 4'b1111, 0);
        tbl[3]  = mk(0, 0,            0, 0,            0, 2'd0, 0,            0, 0,            0, 0, 32'h1c000024, 1, 4'b1110, 1);
        tbl[4]  = mk(0, 0,            0, 0,            0, 2'd0, 0,            0, 0,            0, 0, 32'h1c000030, 1, 4'b1111, 0);
        tbl[5]  = mk(1, 32'h1c000100, 0, 0,            0, 2'd0, 0,            0, 0,            0, 0, 32'h1c000040, 1, 4'b1111, 0);
        tbl[6]  = mk(0, 0,            0, 0,            1, 2'd1, 32'h1c000200, 0, 0,            0, 0, 32'h1c000100, 1, 4'b0011, 1);
        tbl[7]  = mk(0, 0,            0, 0,            0, 2'd0, 0,            0, 0,            0, 1, 32'h1c000200, 0, 4'b0000, 0);
        tbl[8]  = mk(0, 0,            0, 0,            0, 2'd0, 0,            0, 0,            0, 1, 32'h1c000200, 0, 4'b0000, 0);
        tbl[9]  = mk(1, 32'h1c008000, 1, 32'h1c000300, 0, 2'd0, 0,            0, 0,            0, 1, 32'h1c000200, 0, 4'b0000, 0);
        tbl[10] = mk(0, 0,            0, 0,            0, 2'd0, 0,            0, 0,            0, 1, 32'h1c008000, 0, 4'b0000, 1);
        tbl[11] = mk(0, 0,            0, 0,            0, 2'd0, 0,            0, 0,            0, 0, 32'h1c008000, 1, 4'b1111, 0);
        tbl[12] = mk(0, 0,            0, 0,            0, 2'd0, 0,            1, 32'h1c000404, 0, 0, 32'h1c008010, 1, 4'b1111, 0);

        #2;
        do_reset();

        foreach (tbl[n]) begin
            excp_flush = tbl[n].excp; excp_target = tbl[n].excp_t;
            ex_br = tbl[n].br;        ex_br_target = tbl[n].br_t;
            pred_taken = tbl[n].pt;   pred_slot = tbl[n].ps; pred_target = tbl[n].pt_t;
            idle_req = tbl[n].idle;   idle_resume_pc = tbl[n].idle_pc;
            wake_int = tbl[n].wake;   stall_icache = tbl[n].stall;
            #1;
            chk($sformatf("tbl%0d_pc", n), pc4, tbl[n].e_pc);
            chk($sformatf("tbl%0d_valid", n), {31'b0, iv4}, {31'b0, tbl[n].e_valid});
            chk($sformatf("tbl%0d_slot", n), {28'b0, sv4}, {28'b0, tbl[n].e_slot});
            chk($sformatf("tbl%0d_rq", n), {31'b0, rq4}, {31'b0, tbl[n].e_rq});
            model_check();
            tick();
        end

        // Parked in IDLE: PC stays at the resume address, nothing is fetched.
        clr_inputs();
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("idle_pc", pc4, 32'h1c000404);
            chk("idle_valid", {31'b0, iv4}, 32'd0);
            model_check();
            tick();
        end
        wake_int = 1'b1;
        #1; model_check(); tick();
        clr_inputs();
        #1;
        chk("wake_pc", pc4, 32'h1c000404);
        chk("wake_valid", {31'b0, iv4}, 32'd1);
        chk("wake_slot", {28'b0, sv4}, 32'h0000000e);
        model_check();
        tick();

        // Asynchronous reset while in IDLE.
        idle_req = 1'b1; idle_resume_pc = 32'h1c000500;
        #1; model_check(); tick();
        clr_inputs();
        #1; model_check();
        #1;
        do_reset();
        #1;
        chk("boot_valid", {30'b0, iv4, iv2}, 32'd0);
        model_check(); tick();
        #1;
        chk("run_valid", {30'b0, iv4, iv2}, 32'd3);
        chk("run_pc", pc4, RPC);
        model_check(); tick();

        // Randomised traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            excp_flush     = ($urandom_range(0, 15) == 0);
            ex_br          = ($urandom_range(0, 7) == 0);
            idle_req       = !ex_br && ($urandom_range(0, 15) == 0);
            wake_int       = ($urandom_range(0, 5) == 0);
            stall_icache   = ($urandom_range(0, 4) == 0);
            stall_ibuf     = ($urandom_range(0, 4) == 0);
            pred_taken     = ($urandom_range(0, 2) == 0);
            pred_slot      = 2'($urandom_range(0, 3));
            excp_target    = $urandom;
            ex_br_target   = $urandom;
            pred_target    = $urandom;
            idle_resume_pc = $urandom;
            #1;
            model_check();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
